// File: rtl/uart_rx_fifo_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_pkg
// Shared definitions for the UART receiver + FIFO block:
//   - receiver FSM state encoding (legacy-style 2-bit constants)
//   - bit-period and half-bit-period computation from clock and baud rate
//   - clog2 helper used for pointer, level and counter widths
// No ports (package).
// -----------------------------------------------------------------------------
package uart_rx_fifo_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Smallest n with 2**n >= value.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Clock cycles per serial bit, truncated.
    function automatic int calc_bitcnt(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Cycles from the start-bit edge to the middle of the start bit.
    function automatic int calc_halfbit(input int clk_hz, input int baud);
        return (clk_hz / baud) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_if
// CPU register-side bundle of the UART receive FIFO.
//   rd         : single-cycle pop strobe          (CPU -> FIFO)
//   clr_err    : single-cycle sticky-flag clear   (CPU -> FIFO)
//   dout       : head byte, show-ahead            (FIFO -> CPU)
//   data_avail : FIFO not empty                   (FIFO -> CPU)
//   level      : occupancy, 0..DEPTH              (FIFO -> CPU)
//   overflow   : sticky, byte dropped while full  (FIFO -> CPU)
//   frame_err  : sticky, low stop bit seen        (FIFO -> CPU)
// modport master = CPU side, modport slave = uart_rx_fifo.
// -----------------------------------------------------------------------------
interface uart_rx_fifo_if
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH = 16
);
    localparam int LW = clog2(DEPTH) + 1;

    logic          rd;
    logic          clr_err;
    logic [7:0]    dout;
    logic          data_avail;
    logic [LW-1:0] level;
    logic          overflow;
    logic          frame_err;

    modport master (
        output rd,
        output clr_err,
        input  dout,
        input  data_avail,
        input  level,
        input  overflow,
        input  frame_err
    );

    modport slave (
        input  rd,
        input  clr_err,
        output dout,
        output data_avail,
        output level,
        output overflow,
        output frame_err
    );

endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock byte FIFO with show-ahead head output.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write i_din (ignored when full unless a pop happens too)
//   i_din      : byte to write
//   i_pop      : remove head entry (ignored when empty)
//   o_dout     : head entry, combinational from storage (0x00 when empty)
//   o_level    : occupancy 0..DEPTH
//   o_full     : level == DEPTH
//   o_empty    : level == 0
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_push,
    input  logic [7:0]  i_din,
    input  logic        i_pop,
    output logic [7:0]  o_dout,
    output logic [AW:0] o_level,
    output logic        o_full,
    output logic        o_empty
);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;
    logic          w_do_pop;
    logic          w_do_push;

    assign o_full    = (r_level == (AW+1)'(DEPTH));
    assign o_empty   = (r_level == '0);
    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    // Gating on empty makes the head read as 0x00 out of reset without resetting storage.
    assign o_dout    = o_empty ? 8'h00 : r_mem[r_rptr];
    assign o_level   = r_level;

    // Storage write port.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); level tracks push minus pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// 8N1 UART receiver feeding a byte FIFO, with sticky error flags and
// hysteretic RTS flow control.
//   clk28    : system clock (sole clock)
//   rst_n    : asynchronous active-low reset
//   uart_rx  : raw serial input, asynchronous, idle high
//   uart_rts : registered, active-low ready (1 = stop sending)
//   bus      : CPU-side bundle (rd, clr_err, dout, data_avail, level,
//              overflow, frame_err), slave modport
// -----------------------------------------------------------------------------
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int CLK_HZ   = 28000000,
    parameter int BAUD     = 115200,
    parameter int DEPTH    = 16,
    parameter int HI_WATER = 12,
    parameter int LO_WATER = 8
) (
    input  logic          clk28,
    input  logic          rst_n,
    input  logic          uart_rx,
    output logic          uart_rts,
    uart_rx_fifo_if.slave bus
);

    localparam int AW     = clog2(DEPTH);
    localparam int BITCNT = calc_bitcnt(CLK_HZ, BAUD);
    localparam int HALF   = calc_halfbit(CLK_HZ, BAUD);
    localparam int CW     = clog2(BITCNT + 1);

    // Synchronizer and line-qualification state.
    logic          r_sync1;
    logic          r_sync2;
    logic          r_rx_prev;
    logic [1:0]    r_fill;
    logic          r_armed;

    // Receiver state.
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_push;
    logic          r_stop_bad;

    // Flags and flow control.
    logic          r_overflow;
    logic          r_frame_err;
    logic          r_rts;

    logic          w_rx;
    logic          w_fall;
    logic          w_tick;
    logic          w_ferr_evt;
    logic          w_drop;
    logic [7:0]    w_dout;
    logic [AW:0]   w_level;
    logic          w_full;
    logic          w_empty;

    assign w_rx   = r_sync2;
    // Only a falling edge seen after the line was genuinely high starts a frame,
    // so a line that is low when reset releases cannot fake a start bit.
    assign w_fall = r_armed & r_rx_prev & ~w_rx;
    assign w_tick = (r_cnt == '0);
    assign w_ferr_evt = (r_state == ST_STOP) & ~r_stop_bad & w_tick & ~w_rx;
    // Push while full is dropped unless a real pop frees a slot in the same cycle.
    assign w_drop = r_push & w_full & ~(bus.rd & ~w_empty);

    // Two-flop synchronizer, edge history, and arming once the line is seen high.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
            r_fill    <= 2'b00;
            r_armed   <= 1'b0;
        end else begin
            r_sync1   <= uart_rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
            // r_fill[1] marks that r_sync2 now holds a real sample, not the reset value.
            r_fill    <= {r_fill[0], 1'b1};
            if (r_fill[1] & r_sync2) begin
                r_armed <= 1'b1;
            end else begin
                r_armed <= r_armed;
            end
        end
    end

    // Receiver FSM: mid-bit sampling driven by a down-counter, push one cycle after stop sample.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'h00;
            r_push     <= 1'b0;
            r_stop_bad <= 1'b0;
        end else begin
            r_push <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_state <= ST_START;
                        r_cnt   <= CW'(HALF - 1);
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        if (!w_rx) begin
                            r_state   <= ST_DATA;
                            r_cnt     <= CW'(BITCNT - 1);
                            r_bit_idx <= 3'd0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        r_shift <= {w_rx, r_shift[7:1]};
                        r_cnt   <= CW'(BITCNT - 1);
                        if (r_bit_idx == 3'd7) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_STOP: begin
                    if (r_stop_bad) begin
                        // Hold off until the line idles, so a long low is not seen as a new start.
                        if (w_rx) begin
                            r_stop_bad <= 1'b0;
                            r_state    <= ST_IDLE;
                        end
                    end else if (w_tick) begin
                        if (w_rx) begin
                            r_push  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_stop_bad <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky flags (new events win over clear) and RTS hysteresis.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
            r_rts       <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.clr_err) begin
                r_overflow <= 1'b0;
            end else begin
                r_overflow <= r_overflow;
            end

            if (w_ferr_evt) begin
                r_frame_err <= 1'b1;
            end else if (bus.clr_err) begin
                r_frame_err <= 1'b0;
            end else begin
                r_frame_err <= r_frame_err;
            end

            if (w_level >= (AW+1)'(HI_WATER)) begin
                r_rts <= 1'b1;
            end else if (w_level <= (AW+1)'(LO_WATER)) begin
                r_rts <= 1'b0;
            end else begin
                r_rts <= r_rts;
            end
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk28),
        .rst_n   (rst_n),
        .i_push  (r_push),
        .i_din   (r_shift),
        .i_pop   (bus.rd),
        .o_dout  (w_dout),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign uart_rts       = r_rts;
    assign bus.dout       = w_dout;
    assign bus.data_avail = ~w_empty;
    assign bus.level      = w_level;
    assign bus.overflow   = r_overflow;
    assign bus.frame_err  = r_frame_err;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
// Self-checking bench for uart_rx_fifo at default parameters: reset values,
// a table of frames with expected results, randomized frames against a
// queue-based reference model, FIFO fill/overflow/drain with RTS hysteresis,
// a start glitch, and a reset in the middle of a frame.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;
    import uart_rx_fifo_pkg::*;

    localparam int CLK_HZ = 28000000;
    localparam int BAUD   = 115200;
    localparam int DEPTH  = 16;
    localparam int HI     = 12;
    localparam int LO     = 8;
    localparam int BITCNT = CLK_HZ / BAUD;

    logic clk28   = 1'b0;
    logic rst_n   = 1'b0;
    logic uart_rx = 1'b1;
    logic uart_rts;

    uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(
        .CLK_HZ   (CLK_HZ),
        .BAUD     (BAUD),
        .DEPTH    (DEPTH),
        .HI_WATER (HI),
        .LO_WATER (LO)
    ) dut (
        .clk28    (clk28),
        .rst_n    (rst_n),
        .uart_rx  (uart_rx),
        .uart_rts (uart_rts),
        .bus      (bus)
    );

    always #18 clk28 = ~clk28;

    int total = 0;
    int bad   = 0;

    // Reference model: FIFO contents, sticky flags, RTS state.
    logic [7:0] m_q [$];
    logic       m_ovf  = 1'b0;
    logic       m_ferr = 1'b0;
    logic       m_rts  = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [4:0] exp_level;
        logic       exp_ferr;
        logic [7:0] exp_dout;
        logic       do_clr;
        logic       do_rd;
        logic [4:0] exp_level_after;
        logic       exp_ferr_after;
        logic [7:0] exp_dout_after;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void m_upd_rts();
        if (m_q.size() >= HI) m_rts = 1'b1;
        else if (m_q.size() <= LO) m_rts = 1'b0;
    endfunction

    function automatic void m_rx(input logic [7:0] b, input logic stop);
        if (!stop) m_ferr = 1'b1;
        else if (m_q.size() == DEPTH) m_ovf = 1'b1;
        else begin
            m_q.push_back(b);
            m_upd_rts();
        end
    endfunction

    function automatic void m_pop();
        if (m_q.size() != 0) void'(m_q.pop_front());
        m_upd_rts();
    endfunction

    task automatic check_model(input string tag);
        check({tag, " level"}, 32'(bus.level), 32'(m_q.size()));
        check({tag, " avail"}, 32'(bus.data_avail), 32'(m_q.size() != 0));
        check({tag, " ovf"},   32'(bus.overflow), 32'(m_ovf));
        check({tag, " ferr"},  32'(bus.frame_err), 32'(m_ferr));
        check({tag, " rts"},   32'(uart_rts), 32'(m_rts));
        if (m_q.size() != 0) check({tag, " dout"}, 32'(bus.dout), 32'(m_q[0]));
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk28);
        #1;
    endtask

    task automatic send_bit(input logic v);
        uart_rx = v;
        wait_cycles(BITCNT);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        uart_rx = 1'b1;
        wait_cycles(8);
    endtask

    task automatic pulse_rd();
        bus.rd = 1'b1;
        wait_cycles(1);
        bus.rd = 1'b0;
        wait_cycles(2);
    endtask

    task automatic pulse_clr();
        bus.clr_err = 1'b1;
        wait_cycles(1);
        bus.clr_err = 1'b0;
        wait_cycles(2);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " level"}, 32'(bus.level), 32'd0);
        check({tag, " avail"}, 32'(bus.data_avail), 32'd0);
        check({tag, " ovf"},   32'(bus.overflow), 32'd0);
        check({tag, " ferr"},  32'(bus.frame_err), 32'd0);
        check({tag, " rts"},   32'(uart_rts), 32'd0);
        check({tag, " dout"},  32'(bus.dout), 32'd0);
        check({tag, " state"}, 32'(dut.r_state), 32'(ST_IDLE));
        check({tag, " sync1"}, 32'(dut.r_sync1), 32'd1);
        check({tag, " sync2"}, 32'(dut.r_sync2), 32'd1);
    endtask

    // Watchdog: the sequence uses fixed cycle counts, this only guards against a stall.
    initial begin
        #5000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        logic       s;
        int         npop;

        bus.rd      = 1'b0;
        bus.clr_err = 1'b0;

        //                data   stop  lvl  ferr dout  clr   rd    lvl' ferr' dout'
        vecs[0] = '{8'h55, 1'b1, 5'd1, 1'b0, 8'h55, 1'b0, 1'b1, 5'd0, 1'b0, 8'h00};
        vecs[1] = '{8'hA3, 1'b0, 5'd0, 1'b1, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 5'd1, 1'b0, 8'hFF, 1'b0, 1'b0, 5'd1, 1'b0, 8'hFF};
        vecs[3] = '{8'h00, 1'b1, 5'd2, 1'b0, 8'hFF, 1'b0, 1'b1, 5'd1, 1'b0, 8'h00};
        vecs[4] = '{8'h3C, 1'b0, 5'd1, 1'b1, 8'h00, 1'b1, 1'b1, 5'd0, 1'b0, 8'h00};

        // Reset state.
        wait_cycles(3);
        check_reset_values("reset");
        rst_n = 1'b1;
        wait_cycles(5);
        check_model("idle");

        // Short low glitch must be rejected at the start-bit mid sample.
        uart_rx = 1'b0;
        wait_cycles(56);
        uart_rx = 1'b1;
        wait_cycles(BITCNT);
        check("glitch level", 32'(bus.level), 32'd0);
        check("glitch ferr",  32'(bus.frame_err), 32'd0);
        check("glitch state", 32'(dut.r_state), 32'(ST_IDLE));

        // Table of frames with fixed expectations.
        for (int i = 0; i < 5; i++) begin
            send_frame(vecs[i].data, vecs[i].stop);
            check($sformatf("vec%0d level", i), 32'(bus.level), 32'(vecs[i].exp_level));
            check($sformatf("vec%0d avail", i), 32'(bus.data_avail), 32'(vecs[i].exp_level != 5'd0));
            check($sformatf("vec%0d ferr", i),  32'(bus.frame_err), 32'(vecs[i].exp_ferr));
            if (vecs[i].exp_level != 5'd0)
                check($sformatf("vec%0d dout", i), 32'(bus.dout), 32'(vecs[i].exp_dout));
            if (vecs[i].do_clr) pulse_clr();
            if (vecs[i].do_rd) pulse_rd();
            check($sformatf("vec%0d level'", i), 32'(bus.level), 32'(vecs[i].exp_level_after));
            check($sformatf("vec%0d ferr'", i),  32'(bus.frame_err), 32'(vecs[i].exp_ferr_after));
            if (vecs[i].exp_level_after != 5'd0)
                check($sformatf("vec%0d dout'", i), 32'(bus.dout), 32'(vecs[i].exp_dout_after));
        end

        // Randomized frames, pops and clears against the model.
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom_range(0, 255));
            s = ($urandom_range(0, 4) != 0);
            send_frame(b, s);
            m_rx(b, s);
            check_model($sformatf("rnd%0d rx", i));
            npop = $urandom_range(0, 2);
            for (int k = 0; k < npop; k++) begin
                pulse_rd();
                m_pop();
            end
            if ($urandom_range(0, 1) == 1) begin
                pulse_clr();
                m_ovf  = 1'b0;
                m_ferr = 1'b0;
            end
            check_model($sformatf("rnd%0d act", i));
        end
        while (m_q.size() != 0) begin
            pulse_rd();
            m_pop();
        end
        pulse_clr();
        m_ovf  = 1'b0;
        m_ferr = 1'b0;
        check_model("drained");
        // Pop on empty is ignored.
        pulse_rd();
        m_pop();
        check_model("rd empty");

        // Fill past capacity with no reads: RTS rises at HI, 17th byte dropped.
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b1);
            m_rx(8'(i), 1'b1);
            check_model($sformatf("fill%0d", i));
        end
        check("full level", 32'(bus.level), 32'd16);
        check("full ovf",   32'(bus.overflow), 32'd1);
        check("full rts",   32'(uart_rts), 32'd1);

        // Drain 15 bytes, watching order and RTS hysteresis on the way down.
        for (int i = 0; i < 15; i++) begin
            check($sformatf("pop%0d head", i), 32'(bus.dout), 32'(i));
            pulse_rd();
            m_pop();
            check_model($sformatf("pop%0d", i));
        end
        check("last head", 32'(bus.dout), 32'h0F);

        // Reset during bit 4 of 0x81 with a byte still queued and overflow set.
        b = 8'h81;
        send_bit(1'b0);
        for (int j = 0; j < 4; j++) send_bit(b[j]);
        uart_rx = b[4];
        wait_cycles(BITCNT / 2);
        rst_n = 1'b0;
        wait_cycles(3);
        check_reset_values("midrst");
        rst_n = 1'b1;
        m_q.delete();
        m_ovf  = 1'b0;
        m_ferr = 1'b0;
        m_rts  = 1'b0;
        wait_cycles(BITCNT - BITCNT / 2 - 3);
        for (int j = 5; j < 8; j++) send_bit(b[j]);
        send_bit(1'b1);
        wait_cycles(8);
        check_model("aborted");
        check("aborted state", 32'(dut.r_state), 32'(ST_IDLE));
        send_frame(8'h7E, 1'b1);
        m_rx(8'h7E, 1'b1);
        check_model("after rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
